timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
Top-level sequencer for the kitchen-timer design. Turns debounced button levels into one-cycle plus/minus/reset pulses for the setpoint block, and loads the setpoint (tens of minutes, minutes, 30 s half-step) into a BCD mm:ss countdown. It then runs, pauses and cancels the countdown on a 1 Hz tick, raises the alarm at 00:00, and drives four BCD display digits.

Parameters:
ALARM_TICKS, 10, number of ticks the alarm stays asserted before automatic return to SETUP (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle enable, 1 Hz
btn_plus  in  1  debounced level, synchronous to clk
btn_minus  in  1  debounced level
btn_start  in  1  debounced level, start/pause toggle
btn_cancel  in  1  debounced level
set_hi  in  4  setpoint tens-of-minutes digit, BCD 0..9
set_lo  in  4  setpoint minutes digit, BCD 0..9
set_half  in  1  setpoint adds 30 s
set_plus  out  1  one-cycle increment pulse to setpoint block
set_minus  out  1  one-cycle decrement pulse to setpoint block
set_reset  out  1  one-cycle clear pulse to setpoint block
d3, d2, d1, d0  out  4 each  display digits, BCD, d3 = most significant
alarm  out  1  alarm drive
state  out  2  0=SETUP 1=RUN 2=PAUSE 3=ALARM
disp_en  out  1  display enable

Behaviour:
- Reset (async, active-high) values: state=SETUP; countdown=00:00; all pulse outputs=0; alarm=0; disp_en=1; alarm counter=0; button history registers=1, so a button held through reset does not fire.
- Press detect: press_x = btn_x & ~btn_x_q, evaluated per clk. At most one press per button per level rise.
- Pulse outputs are registered and high for exactly 1 cycle, in the cycle after the press is sampled.
- set_plus and set_minus are generated only in SETUP. If plus and minus are pressed in the same cycle, neither is issued.
- set_reset is issued on press_cancel in SETUP.
- SETUP state:
  - press_start with setpoint nonzero (set_hi|set_lo|set_half ≠ 0): load countdown min_hi=set_hi, min_lo=set_lo, sec_hi=set_half?3:0, sec_lo=0, then go to RUN on the same edge.
  - press_start with setpoint zero: ignored.
- RUN state:
  - tick: BCD decrement. sec_lo 0→9 with borrow; sec_hi 0→5 with borrow; min_lo 0→9 with borrow; min_hi −1.
  - The decrement that yields 00:00 moves to ALARM on the same edge.
  - press_start → PAUSE. press_cancel → SETUP; countdown is kept but not shown.
  - Simultaneous tick + press_start: decrement applies and state goes to PAUSE, unless the result is 00:00, in which case ALARM wins.
  - Simultaneous press_start + press_cancel: cancel wins.
- PAUSE state: tick ignored for counting. press_start → RUN. press_cancel → SETUP.
- ALARM state:
  - alarm=1; counter increments on tick.
  - On reaching ALARM_TICKS: alarm=0, go to SETUP.
  - Any press of any button → SETUP immediately, alarm=0, counter cleared.
  - The setpoint is retained, so restart is one press.
- Display:
  - SETUP: d3=set_hi, d2=set_lo, d1=set_half?3:0, d0=0.
  - RUN/PAUSE: countdown digits.
  - ALARM: 0,0,0,0.
  - Display is registered with 1-cycle latency from state/count change.
- Countdown never underflows: decrement is suppressed at 00:00. Maximum load is 99:30.
- Reset mid-RUN: immediate return to reset values; no pulses are emitted.

Optional Feature:
PAUSE_BLINK_EN. When defined, disp_en toggles on every tick while in PAUSE or ALARM, and is forced to 1 on entry to RUN or SETUP. When undefined, disp_en is constantly 1 and no toggle flop is synthesized.

Test Plan:
- Reset, then press btn_plus 3 times in SETUP → exactly 3 single-cycle set_plus pulses. With set_hi=0, set_lo=1, set_half=1 driven, display reads 0,1,3,0.
- set_hi=0, set_lo=1, set_half=0, press start → RUN with display 0,1,0,0. After 1 tick → 0,0,5,9. After 60 ticks total → state=ALARM, alarm=1.
- RUN at 00:45, press start on the same cycle as tick → PAUSE showing 00:44. 5 further ticks → still 00:44. Press start → RUN; next tick → 00:43.
- ALARM with ALARM_TICKS=10 → alarm stays high for 10 ticks, then state=SETUP, alarm=0. Repeat, and press btn_minus during ALARM → immediate SETUP with no set_minus pulse.
- Setpoint 00:00 plus press start → remains in SETUP. Plus and minus pressed in the same cycle → no pulse. Press cancel in SETUP → single set_reset pulse.
- Assert reset mid-RUN at 12:30 → state=SETUP, all outputs at reset values. A btn_start held across reset release → no transition until released and re-pressed.

Source files
------------

// File: rtl/timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : timer_ctrl                                                 |
// | Description : Kitchen-timer sequencer. Converts button levels into       |
// |               setpoint pulses, loads and runs a BCD mm:ss countdown on a |
// |               1 Hz tick, raises the alarm at 00:00 and drives 4 digits.  |
// |               Optional feature macro: PAUSE_BLINK_EN (display blink in   |
// |               PAUSE/ALARM).                                              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module timer_ctrl #(
   parameter int unsigned ALARM_TICKS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_plus,
   input  logic       btn_minus,
   input  logic       btn_start,
   input  logic       btn_cancel,
   input  logic [3:0] set_hi,
   input  logic [3:0] set_lo,
   input  logic       set_half,
   output logic       set_plus,
   output logic       set_minus,
   output logic       set_reset,
   output logic [3:0] d3,
   output logic [3:0] d2,
   output logic [3:0] d1,
   output logic [3:0] d0,
   output logic       alarm,
   output logic [1:0] state,
   output logic       disp_en
);

   typedef enum logic [1:0] {
      ST_SETUP = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS);

   state_t     state_q, state_d;
   logic [3:0] mh_q, ml_q, sh_q, sl_q;
   logic [3:0] mh_d, ml_d, sh_d, sl_d;
   logic [7:0] acnt_q, acnt_d;
   logic [3:0] btn_q;
   logic       plus_q, minus_q, rst_pulse_q;
   logic       plus_d, minus_d, rst_pulse_d;
   logic [3:0] d3_q, d2_q, d1_q, d0_q;

   logic       press_plus, press_minus, press_start, press_cancel, press_any;
   logic [3:0] dec_mh, dec_ml, dec_sh, dec_sl;
   logic       cnt_zero, dec_zero, set_nonzero;

   // Rising-edge detection against the previous button levels
   assign press_plus   = btn_plus   & ~btn_q[3];
   assign press_minus  = btn_minus  & ~btn_q[2];
   assign press_start  = btn_start  & ~btn_q[1];
   assign press_cancel = btn_cancel & ~btn_q[0];
   assign press_any    = press_plus | press_minus | press_start | press_cancel;

   assign cnt_zero    = ({mh_q, ml_q, sh_q, sl_q} == 16'h0000);
   assign dec_zero    = ({dec_mh, dec_ml, dec_sh, dec_sl} == 16'h0000);
   assign set_nonzero = (set_hi != 4'd0) || (set_lo != 4'd0) || set_half;

   // BCD decrement of mm:ss with borrow chain (seconds tens wrap at 5)
   always_comb begin
      dec_sl = sl_q - 4'd1;
      dec_sh = sh_q;
      dec_ml = ml_q;
      dec_mh = mh_q;
      if (sl_q == 4'd0) begin
         dec_sl = 4'd9;
         dec_sh = sh_q - 4'd1;
         if (sh_q == 4'd0) begin
            dec_sh = 4'd5;
            dec_ml = ml_q - 4'd1;
            if (ml_q == 4'd0) begin
               dec_ml = 4'd9;
               dec_mh = mh_q - 4'd1;
            end
         end
      end
   end

   // Next-state, countdown, alarm counter and setpoint pulse decisions
   always_comb begin
      state_d     = state_q;
      mh_d        = mh_q;
      ml_d        = ml_q;
      sh_d        = sh_q;
      sl_d        = sl_q;
      acnt_d      = acnt_q;
      plus_d      = 1'b0;
      minus_d     = 1'b0;
      rst_pulse_d = 1'b0;
      case (state_q)
         ST_SETUP: begin
            plus_d      = press_plus & ~press_minus;
            minus_d     = press_minus & ~press_plus;
            rst_pulse_d = press_cancel;
            if (press_start && set_nonzero) begin
               mh_d    = set_hi;
               ml_d    = set_lo;
               sh_d    = set_half ? 4'd3 : 4'd0;
               sl_d    = 4'd0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (press_cancel) begin
               // Count is kept so the value is not lost, only hidden
               state_d = ST_SETUP;
            end else begin
               if (tick && !cnt_zero) begin
                  mh_d = dec_mh;
                  ml_d = dec_ml;
                  sh_d = dec_sh;
                  sl_d = dec_sl;
               end
               if (tick && (cnt_zero || dec_zero)) begin
                  state_d = ST_ALARM;
                  acnt_d  = 8'd0;
               end else if (press_start) begin
                  state_d = ST_PAUSE;
               end
            end
         end
         ST_PAUSE: begin
            if (press_cancel) begin
               state_d = ST_SETUP;
            end else if (press_start) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            if (press_any) begin
               state_d = ST_SETUP;
               acnt_d  = 8'd0;
            end else if (tick) begin
               if (acnt_q + 8'd1 >= ALARM_LAST) begin
                  state_d = ST_SETUP;
                  acnt_d  = 8'd0;
               end else begin
                  acnt_d = acnt_q + 8'd1;
               end
            end
         end
      endcase
   end

   // State, countdown, button history and pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_SETUP;
         mh_q        <= 4'd0;
         ml_q        <= 4'd0;
         sh_q        <= 4'd0;
         sl_q        <= 4'd0;
         acnt_q      <= 8'd0;
         btn_q       <= 4'b1111;
         plus_q      <= 1'b0;
         minus_q     <= 1'b0;
         rst_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mh_q        <= mh_d;
         ml_q        <= ml_d;
         sh_q        <= sh_d;
         sl_q        <= sl_d;
         acnt_q      <= acnt_d;
         btn_q       <= {btn_plus, btn_minus, btn_start, btn_cancel};
         plus_q      <= plus_d;
         minus_q     <= minus_d;
         rst_pulse_q <= rst_pulse_d;
      end
   end

   // Registered display digits selected by the current state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d3_q <= 4'd0;
         d2_q <= 4'd0;
         d1_q <= 4'd0;
         d0_q <= 4'd0;
      end else begin
         case (state_q)
            ST_SETUP: begin
               d3_q <= set_hi;
               d2_q <= set_lo;
               d1_q <= set_half ? 4'd3 : 4'd0;
               d0_q <= 4'd0;
            end
            ST_RUN, ST_PAUSE: begin
               d3_q <= mh_q;
               d2_q <= ml_q;
               d1_q <= sh_q;
               d0_q <= sl_q;
            end
            default: begin
               d3_q <= 4'd0;
               d2_q <= 4'd0;
               d1_q <= 4'd0;
               d0_q <= 4'd0;
            end
         endcase
      end
   end

`ifdef PAUSE_BLINK_EN
   logic blink_q;

   // Display blink: forced on when heading to RUN/SETUP, toggled per tick otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_q <= 1'b1;
      end else if (state_d == ST_RUN || state_d == ST_SETUP) begin
         blink_q <= 1'b1;
      end else if (tick && (state_q == ST_PAUSE || state_q == ST_ALARM)) begin
         blink_q <= ~blink_q;
      end
   end

   assign disp_en = blink_q;
`else
   assign disp_en = 1'b1;
`endif

   assign set_plus  = plus_q;
   assign set_minus = minus_q;
   assign set_reset = rst_pulse_q;
   assign d3        = d3_q;
   assign d2        = d2_q;
   assign d1        = d1_q;
   assign d0        = d0_q;
   assign alarm     = (state_q == ST_ALARM);
   assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_timer_ctrl                                              |
// | Description : Directed scoreboard bench for timer_ctrl.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_timer_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       btn_plus = 1'b0;
   logic       btn_minus = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_cancel = 1'b0;
   logic [3:0] set_hi = 4'd0;
   logic [3:0] set_lo = 4'd0;
   logic       set_half = 1'b0;
   logic       set_plus, set_minus, set_reset;
   logic [3:0] d3, d2, d1, d0;
   logic       alarm;
   logic [1:0] state;
   logic       disp_en;

   int    n_pass = 0;
   int    n_total = 0;
   int    plus_cnt = 0;
   int    exp_q[$];
   string tag_q[$];

   timer_ctrl #(.ALARM_TICKS(10)) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .btn_plus(btn_plus), .btn_minus(btn_minus),
      .btn_start(btn_start), .btn_cancel(btn_cancel),
      .set_hi(set_hi), .set_lo(set_lo), .set_half(set_half),
      .set_plus(set_plus), .set_minus(set_minus), .set_reset(set_reset),
      .d3(d3), .d2(d2), .d1(d1), .d0(d0),
      .alarm(alarm), .state(state), .disp_en(disp_en)
   );

   always #5 clk = ~clk;

   // Counts clock cycles with set_plus high
   always @(posedge clk) if (set_plus === 1'b1) plus_cnt++;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input string tag, input int v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check(input int obs);
      int    e;
      string t;
      n_total++;
      if (exp_q.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %0h expected none", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) n_pass++;
         else $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
   endtask

   function automatic int disp();
      return int'({d3, d2, d1, d0});
   endfunction

   task automatic do_tick();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
   endtask

   task automatic press_start();
      btn_start = 1'b1;
      cyc(1);
      btn_start = 1'b0;
      cyc(1);
   endtask

   task automatic check_reset_vals(input string pfx);
      push_exp({pfx, "_state"}, 0);     check(int'(state));
      push_exp({pfx, "_alarm"}, 0);     check(int'(alarm));
      push_exp({pfx, "_set_plus"}, 0);  check(int'(set_plus));
      push_exp({pfx, "_set_minus"}, 0); check(int'(set_minus));
      push_exp({pfx, "_set_reset"}, 0); check(int'(set_reset));
      push_exp({pfx, "_disp_en"}, 1);   check(int'(disp_en));
   endtask

   initial begin
      int p0;
      cyc(2);
      check_reset_vals("rst");
      reset = 1'b0;
      cyc(1);

      // Three plus presses in SETUP, each a single-cycle pulse
      set_hi = 4'd0; set_lo = 4'd1; set_half = 1'b1;
      p0 = plus_cnt;
      for (int i = 0; i < 3; i++) begin
         btn_plus = 1'b1;
         push_exp("plus_hi", 1);
         cyc(1);
         check(int'(set_plus));
         push_exp("plus_lo", 0);
         cyc(1);
         check(int'(set_plus));
         btn_plus = 1'b0;
         cyc(1);
      end
      push_exp("plus_count", 3);   check(plus_cnt - p0);
      push_exp("setup_disp", 16'h0130); check(disp());

      // Start from 01:00, run to alarm
      set_half = 1'b0;
      btn_start = 1'b1;
      push_exp("start_run", 1);
      cyc(1);
      check(int'(state));
      btn_start = 1'b0;
      push_exp("run_disp", 16'h0100);
      cyc(1);
      check(disp());
      push_exp("tick1_disp", 16'h0059);
      do_tick();
      check(disp());
      for (int i = 2; i < 60; i++) do_tick();
      push_exp("tick59_disp", 16'h0001); check(disp());
      push_exp("tick59_state", 1);       check(int'(state));
      do_tick();
      push_exp("alarm_state", 3);  check(int'(state));
      push_exp("alarm_hi", 1);     check(int'(alarm));
      push_exp("alarm_disp", 0);   check(disp());

      // Alarm lasts ALARM_TICKS ticks
      for (int i = 0; i < 9; i++) do_tick();
      push_exp("alarm9_alarm", 1); check(int'(alarm));
      do_tick();
      push_exp("alarm10_state", 0); check(int'(state));
      push_exp("alarm10_alarm", 0); check(int'(alarm));

      // Repeat; minus press cancels alarm without pulse
      press_start();
      for (int i = 0; i < 60; i++) do_tick();
      push_exp("alarm2_state", 3); check(int'(state));
      btn_minus = 1'b1;
      push_exp("minus_setup", 0);
      cyc(1);
      check(int'(state));
      push_exp("minus_nopulse0", 0); check(int'(set_minus));
      push_exp("minus_nopulse1", 0);
      cyc(1);
      check(int'(set_minus));
      btn_minus = 1'b0;
      cyc(1);

      // Pause at 00:45 with coincident tick
      press_start();
      for (int i = 0; i < 15; i++) do_tick();
      push_exp("at45_disp", 16'h0045); check(disp());
      tick = 1'b1; btn_start = 1'b1;
      push_exp("pause_state", 2);
      cyc(1);
      check(int'(state));
      tick = 1'b0; btn_start = 1'b0;
      push_exp("pause_disp", 16'h0044);
      cyc(1);
      check(disp());
      for (int i = 0; i < 5; i++) do_tick();
      push_exp("pause_hold_disp", 16'h0044); check(disp());
      push_exp("pause_hold_state", 2);       check(int'(state));
      press_start();
      push_exp("resume_state", 1); check(int'(state));
      do_tick();
      push_exp("resume_disp", 16'h0043); check(disp());

      // Cancel in RUN returns to SETUP
      btn_cancel = 1'b1;
      push_exp("cancel_run", 0);
      cyc(1);
      check(int'(state));
      btn_cancel = 1'b0;
      cyc(1);

      // Zero setpoint start ignored
      set_hi = 4'd0; set_lo = 4'd0; set_half = 1'b0;
      press_start();
      push_exp("zero_start", 0); check(int'(state));

      // Plus and minus together: no pulse
      btn_plus = 1'b1; btn_minus = 1'b1;
      cyc(1);
      push_exp("both_plus", 0);  check(int'(set_plus));
      push_exp("both_minus", 0); check(int'(set_minus));
      btn_plus = 1'b0; btn_minus = 1'b0;
      cyc(1);

      // Cancel in SETUP: single set_reset pulse
      btn_cancel = 1'b1;
      push_exp("reset_pulse_hi", 1);
      cyc(1);
      check(int'(set_reset));
      push_exp("reset_pulse_lo", 0);
      cyc(1);
      check(int'(set_reset));
      btn_cancel = 1'b0;
      cyc(1);

      // Reset mid-RUN at 12:30 with start held across release
      set_hi = 4'd1; set_lo = 4'd2; set_half = 1'b1;
      press_start();
      push_exp("run1230_disp", 16'h1230); check(disp());
      #2;
      btn_start = 1'b1;
      reset = 1'b1;
      #1;
      check_reset_vals("midrun");
      cyc(1);
      reset = 1'b0;
      cyc(3);
      push_exp("held_start", 0); check(int'(state));
      btn_start = 1'b0;
      cyc(1);
      btn_start = 1'b1;
      push_exp("repress_start", 1);
      cyc(1);
      check(int'(state));
      btn_start = 1'b0;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
